// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Drives the per-stage register enables and flushes for three cases: load-use
// bubbles, EX-stage redirects and data-memory waits. It also keeps saturating
// event counters and a sticky memory-timeout flag.
module pipeline_hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic             uses_rs1_IF_ID,
    input  logic             uses_rs2_IF_ID,
    input  logic [4:0]       rd_ID_EXE,
    input  logic             reg_write_ID_EXE,
    input  logic [1:0]       memtoreg_ID_EXE,
    input  logic             redirect_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             perf_clear,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // The wait counter only needs to reach MEM_TIMEOUT; keep at least one bit
    // so the timeout-disabled build still elaborates.
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [1:0]        MTR_MEM   = 2'b01;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic redirect_taken;
    logic bubble_taken;
    logic timeout_hit;

    // Hazard conditions, evaluated on the current cycle's inputs. x0 never
    // carries a dependency, so rd==0 is excluded from the load-use check.
    assign mem_stall = dmem_req_MEM & ~dmem_ready;
    assign rs1_hit   = uses_rs1_IF_ID & (rs1_IF_ID == rd_ID_EXE);
    assign rs2_hit   = uses_rs2_IF_ID & (rs2_IF_ID == rd_ID_EXE);
    assign load_use  = reg_write_ID_EXE & (memtoreg_ID_EXE == MTR_MEM) &
                       (rd_ID_EXE != 5'd0) & (rs1_hit | rs2_hit);

    // A frozen pipe defers both redirect and bubble; a redirect squashes the
    // ID instruction, so a coincident load-use is not a bubble.
    assign redirect_taken = ~mem_stall & redirect_EX;
    assign bubble_taken   = ~mem_stall & ~redirect_EX & load_use;

    // The flag sets on the edge where the wait counter reaches MEM_TIMEOUT.
    assign timeout_hit = (MEM_TIMEOUT > 0) && (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state logic: MEM_WAIT lasts exactly as long as the access stalls.
    always_comb begin
        // NOTE: a default assignment ahead of any branching keeps this block
        // purely combinational; a missed path would otherwise infer a latch.
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall)  state_nxt = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Output logic: stage enables and flushes by fixed priority.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_en    = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_exe_en = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (redirect_EX) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
        end
    end

    // Wait counter: restarts from zero on every entry to MEM_WAIT, saturates
    // at MEM_TIMEOUT so it never wraps during an arbitrarily long access.
    always_ff @(posedge clk) begin
        if (reset || state == RUN)     wait_cnt <= '0;
        else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Sticky timeout flag; only reset clears it. The access is never aborted.
    always_ff @(posedge clk) begin
        if (reset)            mem_timeout <= 1'b0;
        else if (timeout_hit) mem_timeout <= 1'b1;
    end

    // Saturating event counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            load_use_cnt  <= '0;
            redirect_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (bubble_taken && load_use_cnt != CNT_MAX)
                load_use_cnt <= load_use_cnt + CNT_W'(1);
            if (redirect_taken && redirect_cnt != CNT_MAX)
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            if (mem_stall && mem_stall_cnt != CNT_MAX)
                mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Two instances share every
// input: "a" uses the default parameters, "b" uses CNT_W=2, MEM_TIMEOUT=4 to
// reach counter saturation and the timeout quickly. A cycle model pushes the
// expected outputs into a queue as each step is driven; they are popped and
// compared on the following falling edge.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1_IF_ID, rs2_IF_ID, rd_ID_EXE;
    logic       uses_rs1_IF_ID, uses_rs2_IF_ID, reg_write_ID_EXE;
    logic [1:0] memtoreg_ID_EXE;
    logic       redirect_EX, dmem_req_MEM, dmem_ready, perf_clear;

    logic        pc_en_a, if_id_en_a, id_exe_en_a, ex_mem_en_a, mem_wb_en_a;
    logic        if_id_flush_a, id_exe_flush_a, mem_timeout_a;
    logic [15:0] load_use_cnt_a, redirect_cnt_a, mem_stall_cnt_a;

    logic        pc_en_b, if_id_en_b, id_exe_en_b, ex_mem_en_b, mem_wb_en_b;
    logic        if_id_flush_b, id_exe_flush_b, mem_timeout_b;
    logic [1:0]  load_use_cnt_b, redirect_cnt_b, mem_stall_cnt_b;

    pipeline_hazard_controller dut_a (
        .clk(clk), .reset(reset),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .uses_rs1_IF_ID(uses_rs1_IF_ID), .uses_rs2_IF_ID(uses_rs2_IF_ID),
        .rd_ID_EXE(rd_ID_EXE), .reg_write_ID_EXE(reg_write_ID_EXE),
        .memtoreg_ID_EXE(memtoreg_ID_EXE), .redirect_EX(redirect_EX),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready), .perf_clear(perf_clear),
        .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_exe_en(id_exe_en_a),
        .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
        .if_id_flush(if_id_flush_a), .id_exe_flush(id_exe_flush_a),
        .mem_timeout(mem_timeout_a), .load_use_cnt(load_use_cnt_a),
        .redirect_cnt(redirect_cnt_a), .mem_stall_cnt(mem_stall_cnt_a)
    );

    pipeline_hazard_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .uses_rs1_IF_ID(uses_rs1_IF_ID), .uses_rs2_IF_ID(uses_rs2_IF_ID),
        .rd_ID_EXE(rd_ID_EXE), .reg_write_ID_EXE(reg_write_ID_EXE),
        .memtoreg_ID_EXE(memtoreg_ID_EXE), .redirect_EX(redirect_EX),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready), .perf_clear(perf_clear),
        .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_exe_en(id_exe_en_b),
        .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
        .if_id_flush(if_id_flush_b), .id_exe_flush(id_exe_flush_b),
        .mem_timeout(mem_timeout_b), .load_use_cnt(load_use_cnt_b),
        .redirect_cnt(redirect_cnt_b), .mem_stall_cnt(mem_stall_cnt_b)
    );

    typedef struct {
        logic       reset;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw;
        logic [1:0] mtr;
        logic       redir, req, rdy, clr;
    } stim_t;

    // Control bits packed as {pc, if_id, id_exe, ex_mem, mem_wb, if_flush, id_flush}.
    typedef struct {
        logic [6:0]  ctrl;
        logic [15:0] lu_a, rd_a, ms_a;
        logic [1:0]  lu_b, rd_b, ms_b;
        logic        to_a, to_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   step_no = 0;

    // Model state, index 0 = instance a, 1 = instance b.
    int m_lu[2], m_rd[2], m_ms[2], m_wait[2];
    bit m_to[2];
    bit m_mw;

    function automatic int cnt_max(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    function automatic int tmo(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.reset = 1'b0; s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0;
        s.u1 = 1'b0; s.u2 = 1'b0; s.rw = 1'b0; s.mtr = 2'b00;
        s.redir = 1'b0; s.req = 1'b0; s.rdy = 1'b0; s.clr = 1'b0;
        return s;
    endfunction

    // lw x5 in EX with an ID instruction reading x5 through rs1.
    function automatic stim_t lw_hazard();
        stim_t s = idle();
        s.rd = 5'd5; s.rw = 1'b1; s.mtr = 2'b01; s.rs1 = 5'd5; s.u1 = 1'b1; s.rs2 = 5'd7;
        return s;
    endfunction

    function automatic bit is_stall(input stim_t s);
        return s.req && !s.rdy;
    endfunction

    function automatic bit is_load_use(input stim_t s);
        return s.rw && (s.mtr == 2'b01) && (s.rd != 5'd0) &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    endfunction

    function automatic logic [6:0] exp_ctrl(input stim_t s);
        if (s.reset)          return 7'b00000_11;
        if (is_stall(s))      return 7'b00000_00;
        if (s.redir)          return 7'b11111_11;
        if (is_load_use(s))   return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (step %0d): observed 0x%0h expected 0x%0h", tag, step_no, obs, exp);
        end
    endtask

    // Advance the model across one clock edge.
    task automatic model_edge(input stim_t s);
        bit ms  = is_stall(s);
        bit red = !ms && s.redir;
        bit bub = !ms && !s.redir && is_load_use(s);
        for (int i = 0; i < 2; i++) begin
            if (s.reset) begin
                m_lu[i] = 0; m_rd[i] = 0; m_ms[i] = 0; m_wait[i] = 0; m_to[i] = 1'b0;
            end else begin
                if (s.clr) begin
                    m_lu[i] = 0; m_rd[i] = 0; m_ms[i] = 0;
                end else begin
                    if (bub && m_lu[i] < cnt_max(i)) m_lu[i]++;
                    if (red && m_rd[i] < cnt_max(i)) m_rd[i]++;
                    if (ms  && m_ms[i] < cnt_max(i)) m_ms[i]++;
                end
                if (!m_mw) begin
                    m_wait[i] = 0;
                end else begin
                    if (m_wait[i] < tmo(i)) m_wait[i]++;
                    if (m_wait[i] == tmo(i)) m_to[i] = 1'b1;
                end
            end
        end
        m_mw = s.reset ? 1'b0 : ms;
    endtask

    // Drive one cycle: apply inputs, push expectation, compare on the falling
    // edge, then let the clock edge happen.
    task automatic step(input stim_t s);
        exp_t e;
        exp_t g;
        step_no++;
        reset            = s.reset;
        rs1_IF_ID        = s.rs1;
        rs2_IF_ID        = s.rs2;
        rd_ID_EXE        = s.rd;
        uses_rs1_IF_ID   = s.u1;
        uses_rs2_IF_ID   = s.u2;
        reg_write_ID_EXE = s.rw;
        memtoreg_ID_EXE  = s.mtr;
        redirect_EX      = s.redir;
        dmem_req_MEM     = s.req;
        dmem_ready       = s.rdy;
        perf_clear       = s.clr;
        e.ctrl = exp_ctrl(s);
        e.lu_a = 16'(m_lu[0]); e.rd_a = 16'(m_rd[0]); e.ms_a = 16'(m_ms[0]);
        e.lu_b = 2'(m_lu[1]);  e.rd_b = 2'(m_rd[1]);  e.ms_b = 2'(m_ms[1]);
        e.to_a = m_to[0];      e.to_b = m_to[1];
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        chk("ctrl_a", {pc_en_a, if_id_en_a, id_exe_en_a, ex_mem_en_a, mem_wb_en_a,
                       if_id_flush_a, id_exe_flush_a}, g.ctrl);
        chk("ctrl_b", {pc_en_b, if_id_en_b, id_exe_en_b, ex_mem_en_b, mem_wb_en_b,
                       if_id_flush_b, id_exe_flush_b}, g.ctrl);
        chk("load_use_cnt_a",  load_use_cnt_a,  g.lu_a);
        chk("redirect_cnt_a",  redirect_cnt_a,  g.rd_a);
        chk("mem_stall_cnt_a", mem_stall_cnt_a, g.ms_a);
        chk("load_use_cnt_b",  load_use_cnt_b,  g.lu_b);
        chk("redirect_cnt_b",  redirect_cnt_b,  g.rd_b);
        chk("mem_stall_cnt_b", mem_stall_cnt_b, g.ms_b);
        chk("mem_timeout_a",   mem_timeout_a,   g.to_a);
        chk("mem_timeout_b",   mem_timeout_b,   g.to_b);
        model_edge(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;

        // Bring both instances out of an unknown state before comparing.
        s = idle();
        s.reset = 1'b1;
        reset = 1'b1; rs1_IF_ID = '0; rs2_IF_ID = '0; rd_ID_EXE = '0;
        uses_rs1_IF_ID = 1'b0; uses_rs2_IF_ID = 1'b0; reg_write_ID_EXE = 1'b0;
        memtoreg_ID_EXE = 2'b00; redirect_EX = 1'b0; dmem_req_MEM = 1'b0;
        dmem_ready = 1'b0; perf_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_lu[i] = 0; m_rd[i] = 0; m_ms[i] = 0; m_wait[i] = 0; m_to[i] = 1'b0;
        end
        m_mw = 1'b0;

        // Reset cycle: enables low, flushes high, counters zero.
        step(s);

        // Load-use on rs1: one bubble, then normal.
        step(lw_hazard());
        step(idle());
        chk("t1_load_use_cnt", load_use_cnt_a, 32'd1);

        // No hazard: rd=x0, rs1 not used, not a load, no reg write.
        s = lw_hazard(); s.rd = 5'd0; s.rs1 = 5'd0; step(s);
        s = lw_hazard(); s.u1 = 1'b0; step(s);
        s = lw_hazard(); s.mtr = 2'b10; step(s);
        s = lw_hazard(); s.rw = 1'b0; step(s);
        chk("t2_load_use_cnt", load_use_cnt_a, 32'd1);
        // Hazard through rs2 only.
        s = lw_hazard(); s.u1 = 1'b0; s.u2 = 1'b1; s.rs2 = 5'd5; step(s);
        chk("t2_rs2_load_use_cnt", load_use_cnt_a, 32'd2);

        // Load-use and redirect together: redirect wins, no bubble counted.
        s = lw_hazard(); s.redir = 1'b1; step(s);
        chk("t3_load_use_cnt", load_use_cnt_a, 32'd2);
        chk("t3_redirect_cnt", redirect_cnt_a, 32'd1);

        // Memory wait with a redirect pending throughout.
        s = idle(); s.req = 1'b1; s.redir = 1'b1;
        repeat (3) step(s);
        s.rdy = 1'b1; step(s);
        chk("t4_mem_stall_cnt", mem_stall_cnt_a, 32'd3);
        chk("t4_redirect_cnt",  redirect_cnt_a,  32'd2);
        // Load-use held across a stall, taken in the first free cycle.
        s = lw_hazard(); s.req = 1'b1; step(s);
        step(lw_hazard());
        chk("t4_held_load_use_cnt", load_use_cnt_a, 32'd3);
        chk("t4_held_stall_cnt",    mem_stall_cnt_a, 32'd4);

        // Long memory wait: instance b times out after its 4th MEM_WAIT cycle.
        s = idle(); s.req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(s);
            if (i == 4) chk("t5_timeout_before", mem_timeout_b, 1'b0);
            if (i == 5) chk("t5_timeout_after",  mem_timeout_b, 1'b1);
        end
        s.rdy = 1'b1; step(s);
        step(idle());
        chk("t5_timeout_sticky_b", mem_timeout_b, 1'b1);
        chk("t5_timeout_a",        mem_timeout_a, 1'b0);

        // Redirect counter saturation on the 2-bit instance.
        s = idle(); s.redir = 1'b1;
        repeat (5) step(s);
        chk("t6_redirect_cnt_a", redirect_cnt_a, 32'd7);
        chk("t6_redirect_cnt_b", redirect_cnt_b, 32'd3);
        // Clear beats the same-cycle increment.
        s.clr = 1'b1; step(s);
        chk("t6_clear_redirect_a", redirect_cnt_a, 32'd0);
        chk("t6_clear_redirect_b", redirect_cnt_b, 32'd0);
        chk("t6_clear_keeps_timeout", mem_timeout_b, 1'b1);
        s.clr = 1'b0; step(s);
        // Reset in the middle of MEM_WAIT.
        s = idle(); s.req = 1'b1;
        repeat (2) step(s);
        s.reset = 1'b1; step(s);
        chk("t6_reset_timeout_b",  mem_timeout_b,   1'b0);
        chk("t6_reset_stall_cnt",  mem_stall_cnt_a, 32'd0);
        chk("t6_reset_redirect",   redirect_cnt_a,  32'd0);
        // The wait count restarts from RUN: timeout again after exactly 4 waits.
        s.reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(s);
            if (i == 4) chk("t6_rerun_timeout_before", mem_timeout_b, 1'b0);
        end
        chk("t6_rerun_timeout_after", mem_timeout_b, 1'b1);
        s.rdy = 1'b1; step(s);
        step(idle());

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
